uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter, 8N1 framing (1 start, 8 data LSB-first, no parity, 1 stop).
//   Accepts one byte per tx_start pulse and shifts it out on tx_serial at BAUD_RATE.
//   Bit timing is derived from the system clock by an integer divider.
//   Sits between a host/CPU byte interface and the board TX pin.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency in Hz
//   BAUD_RATE  115_200     serial bit rate in bits/s
//   (derived) CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division; must be >= 2
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  asynchronous, active-high reset
//   tx_data    in   8  byte to send; sampled only in the cycle tx_start is accepted
//   tx_start   in   1  start request; accepted on a rising clk edge while idle
//   tx_busy    out  1  high from acceptance until end of stop bit
//   tx_serial  out  1  serial line; idles high (mark)
// BEHAVIOUR
//   Single clock domain, one clock, asynchronous active-high reset.
//   Reset (async assert, sync release): state=IDLE, tx_serial=1, tx_busy=0,
//     bit counter, clock counter and shift register cleared.
//   Outputs are registered (no combinational path from inputs to outputs).
//   States: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: tx_serial=1, tx_busy=0. If tx_start=1 at a rising edge: latch tx_data,
//     go START; next cycle tx_serial=0 and tx_busy=1 (latency 1 clk).
//   START: hold 0 for exactly CLKS_PER_BIT clocks, then DATA, bit index 0.
//   DATA: drive latched bit[idx], idx 0..7 (LSB first), each held CLKS_PER_BIT
//     clocks; after bit 7 go STOP.
//   STOP: drive 1 for CLKS_PER_BIT clocks, then IDLE; tx_busy falls on entry to IDLE.
//   Frame length: exactly 10*CLKS_PER_BIT clocks of tx_busy=1.
//   Clock counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), wraps to 0
//     on each bit boundary; no fractional-baud correction.
//   tx_start while tx_busy=1: ignored, no queuing; tx_data changes mid-frame ignored.
//   tx_start held high continuously: a new frame starts on the first idle edge,
//     i.e. one idle-high clock between consecutive frames (back-to-back).
//   tx_start high during reset: ignored; first acceptance is after rst deasserts.
//   Reset mid-frame: frame aborted immediately, tx_serial=1, tx_busy=0, state IDLE.
// TESTING
//   Use CLK_FREQ=100, BAUD_RATE=10 (10 clk/bit), 10 ns clk, rst pulsed 20 ns.
//   1) Pulse tx_start 1 clk with tx_data=0x41 -> tx_serial: 0,1,0,0,0,0,0,1,0,1
//      each 100 ns; sampling mid-bit (150 ns after falling edge, then every 100 ns)
//      recovers 0x41; stop bit 1; tx_busy high exactly 100 clks.
//   2) After tx_busy falls, wait 50 ns, send 0x5A -> recovers 0x5A, stop bit 1.
//   3) Pulse tx_start again 30 clks into a frame with tx_data=0xFF -> ignored;
//      current byte transmits unchanged, no second frame follows.
//   4) Assert rst 40 clks into a frame -> tx_serial=1, tx_busy=0 asynchronously;
//      after release, new 0x00 frame transmits correctly (8 data zeros).
//   5) Hold tx_start=1 with tx_data=0xFF -> consecutive frames separated by one
//      idle clock; each decodes as 0xFF.
//   6) Idle check: after reset, no tx_start for 200 clks -> tx_serial=1, tx_busy=0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle between a host and the UART transmitter.
// The host side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_serial;

  modport master (output tx_data, output tx_start, input tx_busy, input tx_serial);
  modport slave  (input tx_data, input tx_start, output tx_busy, output tx_serial);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Each bit lasts CLK_FREQ/BAUD_RATE clocks, and that ratio must be at least 2.
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            busy_q, busy_d;
  logic            bit_done;

  assign bit_done = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            // The shift register keeps the bit that is being sent in bit 0.
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state, so the line changes on the same edge as the state.
    busy_d   = (state_d != StIdle);
    serial_d = 1'b1;
    if (state_d == StStart) begin
      serial_d = 1'b0;
    end else if (state_d == StData) begin
      serial_d = shift_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.tx_serial = serial_q;
  assign bus.tx_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit.
// Frames are decoded by sampling the line in the middle of each bit.
module tb_uart_tx;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ  (100),
    .BAUD_RATE (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call at a negedge. Pulses tx_start for one clock.
  task automatic send_pulse(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Call at a negedge. Waits for the start bit and samples the data bits at 150 + 100*i ns.
  // It also samples the stop bit at 950 ns and counts the clocks during which tx_busy is high.
  // It returns on the first negedge at which tx_busy is low again.
  task automatic rx_frame(output logic [7:0] data, output logic stop_bit,
                          output int busy_clks, output int wait_clks);
    int k;
    data      = '0;
    stop_bit  = 1'b0;
    busy_clks = 0;
    wait_clks = 0;
    while (bus.tx_serial !== 1'b0 && wait_clks < 500) begin
      wait_clks++;
      @(negedge clk);
    end
    k = 0;
    while (bus.tx_busy === 1'b1 && k < 300) begin
      busy_clks++;
      if (k >= 15 && k <= 85 && (k - 15) % 10 == 0) data[(k - 15) / 10] = bus.tx_serial;
      if (k == 95) stop_bit = bus.tx_serial;
      k++;
      @(negedge clk);
    end
  endtask

  logic [7:0] d;
  logic       sb;
  int         bc;
  int         wc;
  int         bad;

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    #20 rst = 1'b0;
    @(negedge clk);

    // Test 6: the line stays idle when no tx_start arrives.
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("idle_200_clks", bad, 0);
    check("reset_serial", bus.tx_serial, 1'b1);
    check("reset_busy", bus.tx_busy, 1'b0);

    // Test 1: a single frame carrying 0x41.
    send_pulse(8'h41);
    rx_frame(d, sb, bc, wc);
    check("t1_latency", wc, 0);
    check("t1_data", d, 8'h41);
    check("t1_stop", sb, 1'b1);
    check("t1_busy_clks", bc, 100);

    // Test 2: send 0x5A 50 ns after tx_busy falls.
    repeat (5) @(negedge clk);
    send_pulse(8'h5A);
    rx_frame(d, sb, bc, wc);
    check("t2_data", d, 8'h5A);
    check("t2_stop", sb, 1'b1);
    check("t2_busy_clks", bc, 100);

    // Test 3: a tx_start and new tx_data in the middle of a frame are ignored.
    repeat (3) @(negedge clk);
    send_pulse(8'h3C);
    fork
      rx_frame(d, sb, bc, wc);
      begin
        repeat (29) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    check("t3_data", d, 8'h3C);
    check("t3_stop", sb, 1'b1);
    check("t3_busy_clks", bc, 100);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t3_no_second_frame", bad, 0);

    // Test 4: reset 40 clocks into a frame aborts the frame at once.
    send_pulse(8'h96);
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_async_serial", bus.tx_serial, 1'b1);
    check("t4_async_busy", bus.tx_busy, 1'b0);
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hFF;
    @(posedge clk);
    #1;
    check("t4_start_in_reset", bus.tx_busy, 1'b0);
    bus.tx_start = 1'b0;
    #16 rst = 1'b0;
    @(negedge clk);
    check("t4_post_reset_serial", bus.tx_serial, 1'b1);
    check("t4_post_reset_busy", bus.tx_busy, 1'b0);
    send_pulse(8'h00);
    rx_frame(d, sb, bc, wc);
    check("t4_latency", wc, 0);
    check("t4_data", d, 8'h00);
    check("t4_stop", sb, 1'b1);
    check("t4_busy_clks", bc, 100);

    // Test 5: holding tx_start high sends back-to-back frames with one idle clock between them.
    repeat (4) @(negedge clk);
    bus.tx_data  = 8'hFF;
    bus.tx_start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rx_frame(d, sb, bc, wc);
      check($sformatf("t5_data_%0d", f), d, 8'hFF);
      check($sformatf("t5_stop_%0d", f), sb, 1'b1);
      check($sformatf("t5_busy_clks_%0d", f), bc, 100);
      // The first frame starts on the first edge. Later frames wait one idle clock.
      check($sformatf("t5_gap_%0d", f), wc, (f == 0) ? 1 : 1);
    end
    bus.tx_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("t5_stops_after_release", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
